// File: rtl/reg_univ.sv
// ---------------------------------------------------------------------------
// reg_univ: universal register with load, inc/dec, shift and rotate.
//
// Parameters
//   WIDTH     register and bus width in bits (2..64)
//   RESET_VAL value loaded by the synchronous reset
//   SATURATE  0: inc/dec wrap around, 1: inc/dec clamp at the limits
//
// Ports
//   clk      rising-edge clock for all state
//   reset_n  synchronous active-low reset
//   Data     parallel load value
//   op       000 hold, 001 load, 010 inc, 011 dec,
//            100 shl (LSB <- ser_in), 101 shr (MSB <- ser_in),
//            110 rotl (LSB <- old MSB), 111 clear
//   ser_in   serial bit entering on shl/shr
//   enable   combinational drive enable for Q
//   Q        register value when enable=1, all-Z otherwise
//   q_int    register value, always driven
//   carry    registered carry/borrow/shifted-out bit
//   zero     combinational (q_int == 0)
// ---------------------------------------------------------------------------
module reg_univ #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] Data,
    input  logic [2:0]       op,
    input  logic             ser_in,
    input  logic             enable,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] q_int,
    output logic             carry,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_ROTL = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    logic [WIDTH-1:0] q_p0;
    logic             carry_p0;

    // Returns {carry, next value}. At all-ones the carry is raised; the value
    // either wraps to zero or sticks at all-ones when saturating.
    function automatic logic [WIDTH:0] inc_step(input logic [WIDTH-1:0] v);
        if (v == ONES)
            inc_step = {1'b1, (SATURATE ? ONES : ZERO)};
        else
            inc_step = {1'b0, v + ONE};
    endfunction

    // Returns {borrow, next value}; mirror image of inc_step at zero.
    function automatic logic [WIDTH:0] dec_step(input logic [WIDTH-1:0] v);
        if (v == ZERO)
            dec_step = {1'b1, (SATURATE ? ZERO : ONES)};
        else
            dec_step = {1'b0, v - ONE};
    endfunction

    // ---- stage p0: register update (reset overrides any op) ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_p0     <= RESET_VAL;
            carry_p0 <= 1'b0;
        end else begin
            case (op)
                OP_HOLD: begin
                    q_p0     <= q_p0;
                    carry_p0 <= carry_p0;
                end
                OP_LOAD: begin
                    q_p0     <= Data;
                    carry_p0 <= 1'b0;
                end
                OP_INC:  {carry_p0, q_p0} <= inc_step(q_p0);
                OP_DEC:  {carry_p0, q_p0} <= dec_step(q_p0);
                OP_SHL: begin
                    q_p0     <= {q_p0[WIDTH-2:0], ser_in};
                    carry_p0 <= q_p0[WIDTH-1];
                end
                OP_SHR: begin
                    q_p0     <= {ser_in, q_p0[WIDTH-1:1]};
                    carry_p0 <= q_p0[0];
                end
                OP_ROTL: begin
                    q_p0     <= {q_p0[WIDTH-2:0], q_p0[WIDTH-1]};
                    carry_p0 <= q_p0[WIDTH-1];
                end
                OP_CLR: begin
                    q_p0     <= ZERO;
                    carry_p0 <= 1'b0;
                end
                default: begin
                    q_p0     <= q_p0;
                    carry_p0 <= carry_p0;
                end
            endcase
        end
    end

    // ---- outputs: combinational views of the p0 register ----
    assign q_int = q_p0;
    assign carry = carry_p0;
    assign zero  = (q_p0 == ZERO);
    assign Q     = enable ? q_p0 : {WIDTH{1'bz}};

endmodule

// File: tb/tb_reg_univ.sv
// ---------------------------------------------------------------------------
// tb_reg_univ: scoreboard bench for reg_univ. Three instances share stimulus:
//   u0: WIDTH=8,  wrap
//   u1: WIDTH=8,  saturate
//   u2: WIDTH=16, RESET_VAL=0x1234, wrap
// The driver pushes hand-computed expectations after each clock edge; an
// independent monitor pops and compares them shortly after the same edge.
// ---------------------------------------------------------------------------
module tb_reg_univ;

    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] INC  = 3'b010;
    localparam logic [2:0] DEC  = 3'b011;
    localparam logic [2:0] SHL  = 3'b100;
    localparam logic [2:0] SHR  = 3'b101;
    localparam logic [2:0] ROTL = 3'b110;
    localparam logic [2:0] CLR  = 3'b111;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] Data = '0;
    logic [2:0]  op = HOLD;
    logic        ser_in = 1'b0;
    logic        enable = 1'b1;

    logic [7:0]  Q0, q0, Q1, q1;
    logic [15:0] Q2, q2;
    logic        c0, z0, c1, z1, c2, z2;

    int total = 0;
    int bad   = 0;
    int step  = 0;

    typedef struct {
        int          id;
        int          st;
        logic [15:0] q;
        logic        c;
        logic        z;
        logic [15:0] qb;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    reg_univ #(.WIDTH(8), .RESET_VAL(8'h00), .SATURATE(1'b0)) u0 (
        .clk(clk), .reset_n(reset_n), .Data(Data[7:0]), .op(op), .ser_in(ser_in),
        .enable(enable), .Q(Q0), .q_int(q0), .carry(c0), .zero(z0));

    reg_univ #(.WIDTH(8), .RESET_VAL(8'h00), .SATURATE(1'b1)) u1 (
        .clk(clk), .reset_n(reset_n), .Data(Data[7:0]), .op(op), .ser_in(ser_in),
        .enable(enable), .Q(Q1), .q_int(q1), .carry(c1), .zero(z1));

    reg_univ #(.WIDTH(16), .RESET_VAL(16'h1234), .SATURATE(1'b0)) u2 (
        .clk(clk), .reset_n(reset_n), .Data(Data), .op(op), .ser_in(ser_in),
        .enable(enable), .Q(Q2), .q_int(q2), .carry(c2), .zero(z2));

    // Apply inputs away from the edge, then return just after the edge that
    // consumed them.
    task automatic drive(input logic rn, input logic [2:0] o, input logic [15:0] d,
                         input logic s, input logic e);
        @(negedge clk);
        reset_n = rn;
        op      = o;
        Data    = d;
        ser_in  = s;
        enable  = e;
        @(posedge clk);
        #1;
        step++;
    endtask

    // Expected state of instance id after the current step.
    task automatic expect_st(input int id, input logic [15:0] q, input logic c);
        exp_t e;
        e.id = id;
        e.st = step;
        e.q  = q;
        e.c  = c;
        e.z  = (q == 16'h0000);
        if (enable)
            e.qb = q;
        else if (id == 2)
            e.qb = 16'hzzzz;
        else
            e.qb = {8'h00, 8'hzz};
        sb.push_back(e);
    endtask

    task automatic check(input string nm, input int id, input int st,
                         input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s u%0d step %0d: got %h required %h", nm, id, st, act, req);
        end
    endtask

    // Monitor: compare everything pushed for this edge.
    initial begin
        exp_t        e;
        logic [15:0] aq, aqb;
        logic        ac, az;
        forever begin
            @(posedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.id)
                    0:       begin aq = {8'h00, q0}; aqb = {8'h00, Q0}; ac = c0; az = z0; end
                    1:       begin aq = {8'h00, q1}; aqb = {8'h00, Q1}; ac = c1; az = z1; end
                    default: begin aq = q2;          aqb = Q2;          ac = c2; az = z2; end
                endcase
                check("q_int", e.id, e.st, aq, e.q);
                check("carry", e.id, e.st, {15'h0, ac}, {15'h0, e.c});
                check("zero",  e.id, e.st, {15'h0, az}, {15'h0, e.z});
                check("Q",     e.id, e.st, aqb, e.qb);
            end
        end
    end

    initial begin
        // Reset with an inc pending: reset wins.
        drive(1'b0, INC, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h0000, 1'b0); expect_st(1, 16'h0000, 1'b0); expect_st(2, 16'h1234, 1'b0);
        drive(1'b0, INC, 16'h0000, 1'b0, 1'b0);
        expect_st(0, 16'h0000, 1'b0); expect_st(2, 16'h1234, 1'b0);
        drive(1'b1, INC, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h0001, 1'b0); expect_st(1, 16'h0001, 1'b0); expect_st(2, 16'h1235, 1'b0);

        // Wrap-around increment.
        drive(1'b1, LOAD, 16'h00FE, 1'b0, 1'b1);
        expect_st(0, 16'h00FE, 1'b0); expect_st(2, 16'h00FE, 1'b0);
        drive(1'b1, INC, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h00FF, 1'b0); expect_st(2, 16'h00FF, 1'b0);
        drive(1'b1, INC, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h0000, 1'b1); expect_st(2, 16'h0100, 1'b0);

        // Decrement: wrap (u0) versus clamp (u1).
        drive(1'b1, LOAD, 16'h0001, 1'b0, 1'b1);
        expect_st(0, 16'h0001, 1'b0); expect_st(1, 16'h0001, 1'b0);
        drive(1'b1, DEC, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h0000, 1'b0); expect_st(1, 16'h0000, 1'b0);
        drive(1'b1, DEC, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h00FF, 1'b1); expect_st(1, 16'h0000, 1'b1);
        drive(1'b1, DEC, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h00FE, 1'b0); expect_st(1, 16'h0000, 1'b1);

        // Increment at all-ones: wrap versus clamp.
        drive(1'b1, LOAD, 16'h00FF, 1'b0, 1'b1);
        expect_st(0, 16'h00FF, 1'b0); expect_st(1, 16'h00FF, 1'b0);
        drive(1'b1, INC, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h0000, 1'b1); expect_st(1, 16'h00FF, 1'b1);

        // Shifts and rotate.
        drive(1'b1, LOAD, 16'h0081, 1'b0, 1'b1);
        expect_st(0, 16'h0081, 1'b0); expect_st(2, 16'h0081, 1'b0);
        drive(1'b1, SHL, 16'h0000, 1'b1, 1'b1);
        expect_st(0, 16'h0003, 1'b1); expect_st(2, 16'h0103, 1'b0);
        drive(1'b1, SHR, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h0001, 1'b1); expect_st(2, 16'h0081, 1'b1);
        drive(1'b1, ROTL, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h0002, 1'b0); expect_st(2, 16'h0102, 1'b0);
        drive(1'b1, LOAD, 16'h0080, 1'b0, 1'b1);
        expect_st(0, 16'h0080, 1'b0);
        drive(1'b1, ROTL, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h0001, 1'b1);
        drive(1'b1, HOLD, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h0001, 1'b1);

        // Hold with enable toggling each cycle.
        drive(1'b1, LOAD, 16'h0055, 1'b0, 1'b1);
        expect_st(0, 16'h0055, 1'b0);
        drive(1'b1, HOLD, 16'h0000, 1'b0, 1'b0);
        expect_st(0, 16'h0055, 1'b0);
        drive(1'b1, HOLD, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h0055, 1'b0);
        drive(1'b1, HOLD, 16'h0000, 1'b0, 1'b0);
        expect_st(0, 16'h0055, 1'b0);

        // Clear drops both value and carry.
        drive(1'b1, LOAD, 16'h00FF, 1'b0, 1'b1);
        expect_st(0, 16'h00FF, 1'b0);
        drive(1'b1, SHL, 16'h0000, 1'b1, 1'b1);
        expect_st(0, 16'h00FF, 1'b1);
        drive(1'b1, CLR, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h0000, 1'b0); expect_st(2, 16'h0000, 1'b0);

        // Reset in the middle of an inc run.
        drive(1'b1, INC, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h0001, 1'b0);
        drive(1'b1, INC, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h0002, 1'b0);
        drive(1'b0, INC, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h0000, 1'b0); expect_st(2, 16'h1234, 1'b0);
        drive(1'b1, INC, 16'h0000, 1'b0, 1'b1);
        expect_st(0, 16'h0001, 1'b0); expect_st(2, 16'h1235, 1'b0);

        repeat (3) @(posedge clk);
        #3;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
